// File: rtl/multi_gateway.sv
// multi_gateway: round-robin bridge from NCH local requesters onto one system bus.
// Sequence per transfer: IDLE -> BREQ (bus request) -> ADDR (one mreq strobe) -> WAIT (for ack)
// -> DONE (one-cycle done pulse). With bus_hog the bus is kept and DONE chains straight to ADDR.
// Optional feature: define MULTI_GATEWAY_TIMEOUT_EN to add the err port and a BREQ/WAIT timeout.
module multi_gateway #(
  parameter int unsigned NCH = 2,
  parameter int unsigned AW  = 24,
  parameter int unsigned DW  = 32,
  parameter int unsigned BW  = 64,
  parameter int unsigned TMO = 255
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    req_wr,
  input  logic [NCH*AW-1:0] req_addr,
  input  logic [NCH*2-1:0]  req_size,
  input  logic [NCH*DW-1:0] req_wdata,
  output logic [NCH-1:0]    done,
  output logic [DW-1:0]     rdata,
  output logic              breq,
  input  logic              back,
  input  logic              bus_hog,
  output logic              mreq,
  output logic              read,
  output logic [AW-1:0]     address,
  output logic [BW-1:0]     wdata,
  output logic [3:0]        width,
  input  logic              ack,
  input  logic [BW-1:0]     data,
  output logic              gate_active
`ifdef MULTI_GATEWAY_TIMEOUT_EN
  ,
  output logic [NCH-1:0]    err
`endif
);

  localparam int unsigned IW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned NLANES = BW / DW;
  localparam int unsigned LSB    = $clog2(DW / 8);
  localparam int unsigned LW     = (NLANES > 1) ? $clog2(NLANES) : 1;

  typedef enum logic [2:0] {StIdle, StBreq, StAddr, StWait, StDone} state_e;

  state_e        state_q;
  logic [IW-1:0] rr_q;
  logic [IW-1:0] sel_q;
  logic          read_q;
  logic          breq_q;
  logic          mreq_q;
  logic          active_q;
  logic [AW-1:0] addr_q;
  logic [3:0]    width_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [NCH-1:0] done_q;

`ifdef MULTI_GATEWAY_TIMEOUT_EN
  logic [9:0]     cnt_q;
  logic [NCH-1:0] err_q;
  logic           tmo_hit;
`endif

  logic [IW:0]    pick_idle;
  logic [IW:0]    pick_hog;
  logic [NCH-1:0] others;
  logic [IW-1:0]  cand;
  logic [IW-1:0]  rr_next;
  logic           c_wr;
  logic [AW-1:0]  c_addr;
  logic [1:0]     c_size;
  logic [DW-1:0]  c_wdata;
  logic [3:0]     c_width;
  logic [LW-1:0]  lane_idx;
  logic [DW-1:0]  lane_data;

  // First asserted request at or after start; MSB of the result flags that one was found.
  function automatic logic [IW:0] rr_pick(input logic [NCH-1:0] r, input logic [IW-1:0] start);
    logic [IW:0] res;
    int unsigned j;
    res = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      j = (32'(start) + 32'(i)) % NCH;
      if (r[IW'(j)]) res = {1'b1, IW'(j)};
    end
    return res;
  endfunction

  // Arbitration candidate and its request fields; in DONE the channel just served is excluded
  always_comb begin
    others        = req;
    others[sel_q] = 1'b0;
    pick_idle     = rr_pick(req, rr_q);
    pick_hog      = rr_pick(others, rr_q);
    cand          = (state_q == StDone) ? pick_hog[IW-1:0] : pick_idle[IW-1:0];
    c_wr          = 1'b0;
    c_addr        = '0;
    c_size        = '0;
    c_wdata       = '0;
    for (int k = 0; k < NCH; k++) begin
      if (cand == IW'(k)) begin
        c_wr    = req_wr[k];
        c_addr  = req_addr[k*AW +: AW];
        c_size  = req_size[k*2 +: 2];
        c_wdata = req_wdata[k*DW +: DW];
      end
    end
    case (c_size)
      2'b00:   c_width = 4'd1;
      2'b01:   c_width = 4'd2;
      default: c_width = 4'd4;
    endcase
    rr_next = (sel_q == IW'(NCH - 1)) ? '0 : sel_q + 1'b1;
  end

  // Read lane selection from the bus data using the low address bits
  always_comb begin
    lane_idx = '0;
    if (NLANES > 1) lane_idx = addr_q[LSB +: LW];
    lane_data = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (lane_idx == LW'(i)) lane_data = data[i*DW +: DW];
    end
  end

`ifdef MULTI_GATEWAY_TIMEOUT_EN
  // Counter is cleared on entry to BREQ/WAIT, so this fires after TMO cycles in the state
  assign tmo_hit = (cnt_q == 10'(TMO - 1));
`endif

  // Gateway sequencer: state, round-robin pointer and registered bus/completion outputs
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q  <= StIdle;
      rr_q     <= '0;
      sel_q    <= '0;
      read_q   <= 1'b0;
      breq_q   <= 1'b0;
      mreq_q   <= 1'b0;
      active_q <= 1'b0;
      addr_q   <= '0;
      width_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      done_q   <= '0;
`ifdef MULTI_GATEWAY_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= '0;
`endif
    end else begin
      done_q <= '0;
`ifdef MULTI_GATEWAY_TIMEOUT_EN
      err_q  <= '0;
      cnt_q  <= cnt_q + 10'd1;
`endif
      unique case (state_q)
        StIdle: begin
          if (pick_idle[IW]) begin
            sel_q    <= cand;
            read_q   <= ~c_wr;
            addr_q   <= c_addr;
            width_q  <= c_width;
            wdata_q  <= c_wdata;
            breq_q   <= 1'b1;
            active_q <= 1'b1;
            state_q  <= StBreq;
`ifdef MULTI_GATEWAY_TIMEOUT_EN
            cnt_q    <= '0;
`endif
          end
        end
        StBreq: begin
          if (back) begin
            mreq_q  <= 1'b1;
            state_q <= StAddr;
          end
`ifdef MULTI_GATEWAY_TIMEOUT_EN
          else if (tmo_hit) begin
            err_q[sel_q] <= 1'b1;
            rdata_q      <= '0;
            rr_q         <= rr_next;
            state_q      <= StDone;
          end
`endif
        end
        StAddr: begin
          mreq_q  <= 1'b0;
          state_q <= StWait;
`ifdef MULTI_GATEWAY_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        StWait: begin
          if (ack) begin
            done_q[sel_q] <= 1'b1;
            rdata_q       <= read_q ? lane_data : '0;
            rr_q          <= rr_next;
            state_q       <= StDone;
          end
`ifdef MULTI_GATEWAY_TIMEOUT_EN
          else if (tmo_hit) begin
            err_q[sel_q] <= 1'b1;
            rdata_q      <= '0;
            rr_q         <= rr_next;
            state_q      <= StDone;
          end
`endif
        end
        StDone: begin
          rdata_q <= '0;
          if (bus_hog && back && pick_hog[IW]) begin
            sel_q   <= cand;
            read_q  <= ~c_wr;
            addr_q  <= c_addr;
            width_q <= c_width;
            wdata_q <= c_wdata;
            mreq_q  <= 1'b1;
            state_q <= StAddr;
          end else begin
            breq_q   <= 1'b0;
            active_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign done        = done_q;
  assign rdata       = rdata_q;
  assign breq        = breq_q;
  assign mreq        = mreq_q;
  assign read        = read_q;
  assign address     = addr_q;
  assign wdata       = {NLANES{wdata_q}};
  assign width       = width_q;
  assign gate_active = active_q;
`ifdef MULTI_GATEWAY_TIMEOUT_EN
  assign err         = err_q;
`endif

endmodule

// File: doc/multi_gateway.md
MULTI_GATEWAY -- requirements
Module: multi_gateway

Interface
REQ-001 Parameter NCH, default 2: number of local requester channels, legal range 1..8.
REQ-002 Parameter AW, default 24: address width.
REQ-003 Parameter DW, default 32: local data width; legal values 16 or 32.
REQ-004 Parameter BW, default 64: system bus data width; BW shall be a multiple of DW, up to 64.
REQ-005 Parameter TMO, default 255: timeout in cycles; legal range 1..1023.
REQ-006 Clock/reset: one clock, sys_clk; reset is synchronous and active-high, port reset.
REQ-007 sys_clk  in  1  system clock; all state changes on its rising edge.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 req  in  NCH  per-channel request; held high until the matching done pulse.
REQ-010 req_wr  in  NCH  per-channel direction: 1 = write, 0 = read.
REQ-011 req_addr  in  NCH*AW  per-channel byte address; channel k occupies slice k.
REQ-012 req_size  in  NCH*2  per-channel size: 00 = byte, 01 = 16-bit, 10 = 32-bit; 11 is treated as 10.
REQ-013 req_wdata  in  NCH*DW  per-channel write data.
REQ-014 done  out  NCH  one-cycle completion pulse to the served channel.
REQ-015 rdata  out  DW  read data, valid in the done cycle.
REQ-016 breq  out  1  system bus request.
REQ-017 back  in  1  system bus grant.
REQ-018 bus_hog  in  1  retain bus ownership between back-to-back transfers.
REQ-019 mreq  out  1  memory cycle strobe.
REQ-020 read  out  1  bus direction: 1 = read.
REQ-021 address  out  AW  bus address.
REQ-022 wdata  out  BW  bus write data.
REQ-023 width  out  4  transfer width in bytes: 1, 2 or 4.
REQ-024 ack  in  1  bus cycle acknowledge.
REQ-025 data  in  BW  bus read data.
REQ-026 gate_active  out  1  high in every state except IDLE.

Function
REQ-027 FSM states are IDLE, BREQ, ADDR, WAIT, DONE.
REQ-028 Arbitration shall be round-robin: in IDLE, the first asserted req at or after pointer rr is selected, and rr becomes selected+1 mod NCH on entry to DONE.
REQ-029 IDLE -> BREQ on any req; the selected channel's wr/addr/size/wdata are registered in the same transition.
REQ-030 breq is high in BREQ, ADDR, WAIT and DONE; BREQ -> ADDR the cycle after back is sampled high.
REQ-031 mreq is high for exactly the single ADDR cycle; address, read, width and wdata hold from ADDR until the end of WAIT.
REQ-032 wdata shall be the registered write data replicated BW/DW times across the bus.
REQ-033 ADDR -> WAIT unconditionally; WAIT -> DONE on the first cycle ack is high, and data is captured in that cycle.
REQ-034 rdata shall be the DW-wide lane of captured data selected by address bits [log2(BW/8)-1 : log2(DW/8)]; rdata is 0 for writes.
REQ-035 DONE lasts one cycle and pulses done for the served channel. Exit to ADDR if bus_hog=1, back=1 and some req other than the one just served is pending (arbitrated as in IDLE); otherwise exit to IDLE.
REQ-036 Once in ADDR, back deassertion is ignored until DONE.
REQ-037 A req that drops before its done pulse does not abort a transfer already in progress.
REQ-038 Minimum latency from req high to done pulse, with back and ack already high, is 5 cycles.

Reset
REQ-039 Reset returns the FSM to IDLE and sets rr=0.
REQ-040 Under reset, done, breq, mreq, read, gate_active, address, wdata, width and rdata are all 0.
REQ-041 Reset asserted mid-transfer takes effect on the next edge with no done pulse.

Configuration
REQ-042 Macro MULTI_GATEWAY_TIMEOUT_EN.
REQ-043 When MULTI_GATEWAY_TIMEOUT_EN is defined: output err (NCH) is added and a 10-bit counter runs in BREQ and WAIT. When the counter reaches TMO, the FSM goes to DONE and pulses err instead of done, with rdata=0.
REQ-044 When MULTI_GATEWAY_TIMEOUT_EN is not defined: there is no err port and no counter, and the FSM waits indefinitely.

Verification
REQ-045 NCH=2. Ch0 reads addr 0x000004 size 10; back=1; ack one cycle after mreq; data=0x11112222_33334444 -> done[0] pulses 5 cycles after req, rdata=0x11112222.
REQ-046 Ch1 writes addr 0x000100 size 01, wdata 0xABCD1234 -> width=2, read=0, wdata=0xABCD1234ABCD1234, exactly one mreq cycle.
REQ-047 Both req high from reset -> service order ch0, ch1, ch0, with rr wrapping correctly.
REQ-048 bus_hog=1 with both requesting -> breq stays high across both transfers and DONE goes directly to ADDR.
REQ-049 Reset asserted in WAIT -> all outputs 0 on the next cycle and no done pulse; TIMEOUT_EN build with ack held 0 -> err pulses after TMO cycles.
